mem_stage_lsu: RTL and testbench

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

---
 rtl/riscv_pkg.sv | 50 +++++
 rtl/lsu_align.sv | 65 ++++++
 rtl/mem_stage_lsu.sv | 165 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_pkg: funct3 load/store encodings, LSU state/size enums, helpers.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int DMEM_TIMEOUT_DEFAULT = 15;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_WAIT = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  // Any encoding that is not a defined byte/half access is treated as a word.
  function automatic lsu_size_e f3_size(input logic [2:0] f3, input logic is_store);
    lsu_size_e sz;
    sz = SZ_WORD;
    if (is_store) begin
      if (f3 == F3_SB)      sz = SZ_BYTE;
      else if (f3 == F3_SH) sz = SZ_HALF;
    end else begin
      if (f3 == F3_LB || f3 == F3_LBU)      sz = SZ_BYTE;
      else if (f3 == F3_LH || f3 == F3_LHU) sz = SZ_HALF;
    end
    return sz;
  endfunction

  function automatic logic f3_unsigned(input logic [2:0] f3);
    return (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_align: byte enables, store lane replication, load lane extraction.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic        st_is_store_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  lsu_size_e st_size;
  lsu_size_e ld_size;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_uns;

  always_comb begin
    st_size = f3_size(st_funct3_i, st_is_store_i);
    be_o    = 4'b1111;
    wdata_o = st_wdata_i;
    case (st_size)
      SZ_BYTE: begin
        be_o    = 4'b0001 << st_addr_lo_i;
        wdata_o = {4{st_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_o    = 4'b0011 << {st_addr_lo_i[1], 1'b0};
        wdata_o = {2{st_wdata_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = st_wdata_i;
      end
    endcase
  end

  always_comb begin
    ld_size = f3_size(ld_funct3_i, 1'b0);
    ld_uns  = f3_unsigned(ld_funct3_i);
    case (ld_addr_lo_i)
      2'd0:    ld_byte = rdata_i[7:0];
      2'd1:    ld_byte = rdata_i[15:8];
      2'd2:    ld_byte = rdata_i[23:16];
      default: ld_byte = rdata_i[31:24];
    endcase
    ld_half = ld_addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (ld_size)
      SZ_BYTE: ld_data_o = ld_uns ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data_o = ld_uns ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_stage_lsu: MEM-stage load/store unit with ready handshake, timeout   |
// | and optional misalignment trap (LSU_MISALIGN_TRAP_EN). Rev 1.0           |
// +--------------------------------------------------------------------------+
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int DMEM_TIMEOUT = DMEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] WriteData_i,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] MemDout_o,
  output logic        MemDout_valid_o,
  output logic        stall_o,
  output logic        bus_err_o,
  output logic        misalign_o
);

  localparam int CW = (DMEM_TIMEOUT < 2) ? 1 : $clog2(DMEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_C = CW'(DMEM_TIMEOUT);

  lsu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]   addr_q, wdata_q, dout_q;
  logic [3:0]    be_q;
  logic [2:0]    f3_q;
  logic          we_q, bus_err_q;

  logic        access, accept, misal, trap_hit, rd_hit, tmo_hit;
  logic [3:0]  align_be;
  logic [31:0] align_wdata, align_ld;

  assign access = valid_i & (MemRead_i | MemWrite_i);
  assign accept = (state_q == LSU_IDLE) & access;

  lsu_align u_align (
    .st_funct3_i  (funct3_i),
    .st_is_store_i(MemWrite_i),
    .st_addr_lo_i (ALUResult_i[1:0]),
    .st_wdata_i   (WriteData_i),
    .be_o         (align_be),
    .wdata_o      (align_wdata),
    .ld_funct3_i  (f3_q),
    .ld_addr_lo_i (addr_q[1:0]),
    .rdata_i      (dmem_rdata),
    .ld_data_o    (align_ld)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  lsu_size_e req_size;
  logic      misal_q;

  always_comb begin
    req_size = f3_size(funct3_i, MemWrite_i);
    misal    = ((req_size == SZ_HALF) & ALUResult_i[0]) |
               ((req_size == SZ_WORD) & (ALUResult_i[1:0] != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (reset) misal_q <= 1'b0;
    else       misal_q <= trap_hit;
  end

  assign misalign_o = misal_q;
`else
  assign misal      = 1'b0;
  assign misalign_o = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cnt_inc  = (cnt_q == TMO_C) ? cnt_q : cnt_q + 1'b1;
    trap_hit = 1'b0;
    rd_hit   = 1'b0;
    tmo_hit  = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (misal) begin
            state_d  = LSU_DONE;
            trap_hit = 1'b1;
          end else begin
            state_d = LSU_WAIT;
          end
        end
      end
      LSU_WAIT: begin
        if (dmem_ready) begin
          state_d = LSU_DONE;
          rd_hit  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TMO_C) begin
            state_d = LSU_DONE;
            tmo_hit = 1'b1;
          end
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LSU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request fields are captured once at acceptance and held for the whole WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      f3_q      <= '0;
      we_q      <= 1'b0;
      dout_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (accept && !misal) begin
        addr_q  <= ALUResult_i;
        wdata_q <= align_wdata;
        be_q    <= align_be;
        f3_q    <= funct3_i;
        we_q    <= MemWrite_i;
      end
      if (rd_hit && !we_q) dout_q <= align_ld;
      else if (tmo_hit)    dout_q <= '0;
      bus_err_q <= tmo_hit;
    end
  end

  assign dmem_req        = (state_q == LSU_WAIT);
  assign dmem_we         = we_q & dmem_req;
  assign dmem_addr       = {addr_q[31:2], 2'b00};
  assign dmem_wdata      = wdata_q;
  assign dmem_be         = be_q;
  assign MemDout_o       = dout_q;
  assign MemDout_valid_o = (state_q == LSU_DONE);
  assign bus_err_o       = bus_err_q;
  assign stall_o         = ((state_q == LSU_IDLE) & access) | (state_q == LSU_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_stage_lsu: randomized self-checking bench with reference model.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mem_stage_lsu;

  localparam int TMO = 15;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk, reset, valid_i, MemRead_i, MemWrite_i;
  logic [2:0]  funct3_i;
  logic [31:0] ALUResult_i, WriteData_i;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, MemDout_o;
  logic [3:0]  dmem_be;
  logic        MemDout_valid_o, stall_o, bus_err_o, misalign_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_dout = 32'd0;

  mem_stage_lsu #(.DMEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .funct3_i(funct3_i), .ALUResult_i(ALUResult_i),
    .WriteData_i(WriteData_i), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .MemDout_o(MemDout_o),
    .MemDout_valid_o(MemDout_valid_o), .stall_o(stall_o), .bus_err_o(bus_err_o),
    .misalign_o(misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: access size in bytes from funct3 and direction.
  function automatic int sz_of(input logic [2:0] f3, input logic st);
    if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int s, lo;
    s  = sz_of(f3, 1'b1);
    lo = int'(a[1:0]);
    if (s == 1) return 4'(1 << lo);
    if (s == 2) return 4'(3 << ((lo / 2) * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] d);
    int s;
    s = sz_of(f3, 1'b1);
    if (s == 1) return {24'd0, d[7:0]} * 32'h0101_0101;
    if (s == 2) return {16'd0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int s;
    logic [31:0] v;
    s = sz_of(f3, 1'b0);
    if (s == 1) begin
      v = (rd >> (8 * int'(a[1:0]))) & 32'hFF;
      if (f3 != 3'd4 && v[7]) v = v | 32'hFFFF_FF00;
    end else if (s == 2) begin
      v = (rd >> (16 * int'(a[1]))) & 32'hFFFF;
      if (f3 != 3'd5 && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic bit m_misal(input logic [2:0] f3, input logic st, input logic [31:0] a);
    int s;
    s = sz_of(f3, st);
    return (s == 2 && a[0]) || (s == 4 && a[1:0] != 2'b00);
  endfunction

  // One complete access; delay = WAIT cycles before ready (-1: never ready).
  task automatic do_access(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input int delay,
                           input logic [31:0] rdat, input logic keep_valid);
    int nwait, stalls, exp_stalls;
    logic [35:0] bus_got, bus_exp;
    stalls = 0;
    @(negedge clk);
    valid_i = 1'b1; MemRead_i = rd; MemWrite_i = wr; funct3_i = f3;
    ALUResult_i = a; WriteData_i = wd; dmem_ready = 1'b0;
    #1;
    n_checks++;
    if ({stall_o, dmem_req, MemDout_valid_o} !== 3'b100) begin
      n_fail++; $display("FAIL %s accept: stall/req/valid got %b want 100", nm, {stall_o, dmem_req, MemDout_valid_o});
    end
    if (stall_o) stalls++;
    if (TRAP && m_misal(f3, wr, a)) begin
      @(negedge clk); valid_i = keep_valid; #1;
      n_checks++;
      if ({misalign_o, dmem_req, MemDout_valid_o, stall_o, bus_err_o} !== 5'b10100 || MemDout_o !== exp_dout) begin
        n_fail++; $display("FAIL %s trap: flags got %b want 10100 dout %h want %h", nm,
          {misalign_o, dmem_req, MemDout_valid_o, stall_o, bus_err_o}, MemDout_o, exp_dout);
      end
      if (!keep_valid) begin
        @(negedge clk); #1;
        n_checks++;
        if ({misalign_o, MemDout_valid_o} !== 2'b00) begin
          n_fail++; $display("FAIL %s trap_end: misalign/valid got %b want 00", nm, {misalign_o, MemDout_valid_o});
        end
      end
      return;
    end
    nwait = (delay < 0) ? TMO : delay + 1;
    for (int k = 0; k < nwait; k++) begin
      @(negedge clk);
      dmem_ready = (k == delay);
      dmem_rdata = (k == delay) ? rdat : $urandom;
      #1;
      if (stall_o) stalls++;
      bus_got = {dmem_req, dmem_we, {a[31:2], 2'b00} ^ dmem_addr, stall_o, MemDout_valid_o};
      bus_exp = {1'b1, wr, 32'd0, 1'b1, 1'b0};
      n_checks++;
      if (bus_got !== bus_exp || bus_err_o !== 1'b0) begin
        n_fail++; $display("FAIL %s wait%0d: req/we/addr/stall/valid got %b,%b,%h,%b,%b want 1,%b,%h,1,0 berr %b", nm, k,
          dmem_req, dmem_we, dmem_addr, stall_o, MemDout_valid_o, wr, {a[31:2], 2'b00}, bus_err_o);
      end
      if (wr) begin
        n_checks++;
        if (dmem_be !== m_be(f3, a) || dmem_wdata !== m_wd(f3, wd)) begin
          n_fail++; $display("FAIL %s store_lanes: be %b wdata %h want %b %h", nm, dmem_be, dmem_wdata, m_be(f3, a), m_wd(f3, wd));
        end
      end
    end
    if (delay < 0) exp_dout = 32'd0;
    else if (!wr)  exp_dout = m_ld(f3, a, rdat);
    @(negedge clk);
    valid_i = keep_valid; dmem_ready = 1'b0; dmem_rdata = $urandom;
    #1;
    exp_stalls = 1 + nwait;
    n_checks++;
    if ({MemDout_valid_o, stall_o, dmem_req, misalign_o} !== 4'b1000 || bus_err_o !== (delay < 0)) begin
      n_fail++; $display("FAIL %s done: valid/stall/req/mis got %b want 1000 berr %b want %b", nm,
        {MemDout_valid_o, stall_o, dmem_req, misalign_o}, bus_err_o, (delay < 0));
    end
    n_checks++;
    if (MemDout_o !== exp_dout) begin
      n_fail++; $display("FAIL %s dout: got %h want %h", nm, MemDout_o, exp_dout);
    end
    n_checks++;
    if (stalls !== exp_stalls) begin
      n_fail++; $display("FAIL %s stall_cycles: got %0d want %0d", nm, stalls, exp_stalls);
    end
    if (!keep_valid) begin
      @(negedge clk); #1;
      n_checks++;
      if ({MemDout_valid_o, bus_err_o, dmem_req, stall_o} !== 4'b0000 || MemDout_o !== exp_dout) begin
        n_fail++; $display("FAIL %s idle: valid/berr/req/stall got %b want 0000 dout %h want %h", nm,
          {MemDout_valid_o, bus_err_o, dmem_req, stall_o}, MemDout_o, exp_dout);
      end
    end
  endtask

  task automatic test_reset();
    valid_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; funct3_i = 3'd0;
    ALUResult_i = 32'd0; WriteData_i = 32'd0; dmem_ready = 1'b0; dmem_rdata = 32'd0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({dmem_req, dmem_we, dmem_be, MemDout_valid_o, bus_err_o, misalign_o, stall_o} !== 10'd0 || MemDout_o !== 32'd0) begin
      n_fail++; $display("FAIL reset_state: flags got %b want 0 dout %h want 0",
        {dmem_req, dmem_we, dmem_be, MemDout_valid_o, bus_err_o, misalign_o, stall_o}, MemDout_o);
    end
    reset = 1'b0;
    exp_dout = 32'd0;
  endtask

  task automatic test_directed();
    do_access("lb_sign", 1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 0, 32'h80FF_FF00, 1'b0);
    n_checks++;
    if (MemDout_o !== 32'hFFFF_FF80) begin
      n_fail++; $display("FAIL lb_const: got %h want ffffff80", MemDout_o);
    end
    do_access("sh_lanes", 1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 0, 32'd0, 1'b0);
    do_access("lhu_wait5", 1'b1, 1'b0, 3'b101, 32'h0000_0000, 32'd0, 5, 32'h1357_F00D, 1'b0);
    do_access("timeout", 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0, -1, 32'd0, 1'b0);
    do_access("lw_reload", 1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'd0, 1, 32'hCAFE_BABE, 1'b0);
    do_access("sw_keep", 1'b0, 1'b1, 3'b010, 32'h0000_0108, 32'h0BAD_F00D, 2, 32'd0, 1'b0);
    do_access("rw_both", 1'b1, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 0, 32'hFFFF_FFFF, 1'b0);
    do_access("misalign", 1'b1, 1'b0, 3'b010, 32'h0000_1002, 32'd0, 0, 32'h1111_2222, 1'b0);
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    valid_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0; funct3_i = 3'b010;
    ALUResult_i = 32'h0000_0040; dmem_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (dmem_req !== 1'b1) begin
      n_fail++; $display("FAIL rst_wait_pre: req got %b want 1", dmem_req);
    end
    @(negedge clk);
    reset = 1'b0; valid_i = 1'b0; dmem_ready = 1'b1; dmem_rdata = 32'h7777_7777;
    #1;
    exp_dout = 32'd0;
    n_checks++;
    if ({dmem_req, MemDout_valid_o, stall_o} !== 3'b000 || MemDout_o !== 32'd0) begin
      n_fail++; $display("FAIL rst_wait_after: req/valid/stall got %b want 000 dout %h want 0",
        {dmem_req, MemDout_valid_o, stall_o}, MemDout_o);
    end
    @(negedge clk);
    dmem_ready = 1'b0;
    #1;
    n_checks++;
    if ({dmem_req, MemDout_valid_o, bus_err_o} !== 3'b000) begin
      n_fail++; $display("FAIL rst_late_ready: req/valid/berr got %b want 000", {dmem_req, MemDout_valid_o, bus_err_o});
    end
  endtask

  task automatic test_back_to_back();
    do_access("b2b_0", 1'b1, 1'b0, 3'b100, 32'h0000_3003, 32'd0, 0, 32'h9A00_0000, 1'b1);
    do_access("b2b_1", 1'b0, 1'b1, 3'b000, 32'h0000_3001, 32'h0000_005A, 0, 32'd0, 1'b1);
    do_access("b2b_2", 1'b1, 1'b0, 3'b001, 32'h0000_3002, 32'd0, 1, 32'h8001_0000, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int kind, dly;
      kind = $urandom_range(1, 3);
      dly  = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 4);
      do_access("random", kind[0], kind[1], 3'($urandom_range(0, 7)), $urandom, $urandom,
                dly, $urandom, 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
